// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: opcode constants, sequencer states and default widths for mem_sequencer
package mem_seq_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DEPTH_W_DEF = 8;
  localparam logic [7:0] OP_HALT = 8'h00;
  localparam logic [7:0] OP_RIGHT = 8'h3E;
  localparam logic [7:0] OP_LEFT = 8'h3C;
  localparam logic [7:0] OP_INC = 8'h2B;
  localparam logic [7:0] OP_DEC = 8'h2D;
  localparam logic [7:0] OP_OPEN = 8'h5B;
  localparam logic [7:0] OP_CLOSE = 8'h5D;
  localparam logic [7:0] OP_OUT = 8'h2E;
  localparam logic [7:0] OP_IN = 8'h2C;
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, TAPE_RD, TAPE_WR, SCAN_FETCH, SCAN, IO_OUT, IO_IN, HALT
  } state_t;
endpackage

// File: rtl/bracket_scan.sv
// bracket_scan: nesting-depth tracker for bracket scans; flags the matching bracket and depth overflow
module bracket_scan import mem_seq_pkg::*; #(
  parameter int DEPTH_W = DEPTH_W_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       step,
  input  logic       backward,
  input  logic [7:0] code,
  output logic       match,
  output logic       overflow
);
  logic [DEPTH_W-1:0] depth;
  logic opener, closer;
  // direction decides which bracket nests deeper and which one closes
  always_comb begin
    opener = code == (backward ? OP_CLOSE : OP_OPEN);
    closer = code == (backward ? OP_OPEN : OP_CLOSE);
    match = step && closer && depth == DEPTH_W'(1);
    overflow = step && opener && &depth;
  end
  // depth starts at 1 for the bracket that launched the scan
  always_ff @(posedge clock or posedge reset)
    if (reset) depth <= '0;
    else if (load) depth <= DEPTH_W'(1);
    else if (step && opener && !overflow) depth <= depth + 1'b1;
    else if (step && closer) depth <= depth - 1'b1;
endmodule

// File: rtl/mem_sequencer.sv
// mem_sequencer: bracket-language instruction sequencer over shared program/tape memory; byte I/O enabled by MEM_SEQ_IO_EN
module mem_sequencer import mem_seq_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH_W = DEPTH_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] addr,
  output logic              progmem_fetch_low,
  output logic              tape_fetch,
  output logic              tape_writeback,
  output logic              pc_writeback,
  input  logic [15:0]       data_in,
  output logic [15:0]       data_out,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              halted,
  output logic              error,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] ptr
);
`ifdef MEM_SEQ_IO_EN
  localparam bit IO_EN = 1'b1;
`else
  localparam bit IO_EN = 1'b0;
`endif
  state_t state;
  logic [7:0] op, in_byte, code, wr_byte;
  logic [ADDR_W-1:0] pc_inc;
  logic backward, scan_start, start_wrap, scan_wrap, load, match, overflow;
  logic unused_hi;
  assign unused_hi = ^data_in[15:8];
  // instruction byte, scan direction and wrap detection at the address-space ends
  always_comb begin
    code = data_in[7:0];
    pc_inc = pc + 1'b1;
    backward = op == OP_CLOSE;
    scan_start = state == TAPE_WR && ((op == OP_OPEN && code == 8'h00) || (op == OP_CLOSE && code != 8'h00));
    start_wrap = backward ? pc == '0 : &pc;
    scan_wrap = backward ? addr == '0 : &addr;
    load = scan_start;
  end
  // write data: tape byte on tape writebacks, new pc on pc writebacks
  always_comb begin
    wr_byte = op == OP_IN ? in_byte : (op == OP_INC ? code + 8'd1 : code - 8'd1);
    data_out = tape_writeback ? {8'h00, wr_byte} : (pc_writeback ? 16'(pc) : 16'h0000);
  end
  bracket_scan #(.DEPTH_W(DEPTH_W)) u_scan (
    .clock(clock), .reset(reset), .load(load), .step(state == SCAN),
    .backward(backward), .code(code), .match(match), .overflow(overflow)
  );
  task automatic next_insn(input logic [ADDR_W-1:0] npc);
    pc <= npc;
    addr <= npc;
    pc_writeback <= 1'b1;
    progmem_fetch_low <= run;
    state <= run ? FETCH : IDLE;
  endtask
  // sequencer: strobes are single-cycle and registered alongside the state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc <= '0;
      ptr <= '0;
      addr <= '0;
      op <= 8'h00;
      in_byte <= 8'h00;
      progmem_fetch_low <= 1'b0;
      tape_fetch <= 1'b0;
      tape_writeback <= 1'b0;
      pc_writeback <= 1'b0;
      out_data <= 8'h00;
      out_valid <= 1'b0;
      in_ready <= 1'b0;
      halted <= 1'b0;
      error <= 1'b0;
    end else begin
      progmem_fetch_low <= 1'b0;
      tape_fetch <= 1'b0;
      tape_writeback <= 1'b0;
      pc_writeback <= 1'b0;
      in_ready <= 1'b0;
      case (state)
        IDLE: if (run) begin
          state <= FETCH;
          addr <= pc;
          progmem_fetch_low <= 1'b1;
        end
        FETCH: state <= DECODE;
        DECODE: begin
          op <= code;
          if (code == OP_RIGHT || code == OP_LEFT) begin
            ptr <= code == OP_RIGHT ? ptr + 1'b1 : ptr - 1'b1;
            next_insn(pc_inc);
          end else if (code == OP_HALT) begin
            halted <= 1'b1;
            state <= HALT;
          end else if (code inside {OP_INC, OP_DEC, OP_OPEN, OP_CLOSE} || (IO_EN && code == OP_OUT)) begin
            tape_fetch <= 1'b1;
            addr <= ptr;
            state <= TAPE_RD;
          end else if (IO_EN && code == OP_IN) state <= IO_IN;
          else next_insn(pc_inc);
        end
        TAPE_RD: if (op == OP_OUT) state <= IO_OUT;
        else begin
          state <= TAPE_WR;
          tape_writeback <= op == OP_INC || op == OP_DEC;
        end
        TAPE_WR: if (scan_start && start_wrap) begin
          error <= 1'b1;
          state <= HALT;
        end else if (scan_start) begin
          addr <= backward ? pc - 1'b1 : pc_inc;
          progmem_fetch_low <= 1'b1;
          state <= SCAN_FETCH;
        end else next_insn(pc_inc);
        SCAN_FETCH: state <= SCAN;
        SCAN: if (overflow || (!match && scan_wrap)) begin
          error <= 1'b1;
          state <= HALT;
        end else if (match) next_insn(addr + 1'b1);
        else begin
          addr <= backward ? addr - 1'b1 : addr + 1'b1;
          progmem_fetch_low <= 1'b1;
          state <= SCAN_FETCH;
        end
        IO_OUT: if (!out_valid) begin
          out_data <= code;
          out_valid <= 1'b1;
        end else if (out_ready) begin
          out_valid <= 1'b0;
          next_insn(pc_inc);
        end
        IO_IN: if (in_valid) begin
          in_ready <= 1'b1;
          in_byte <= in_data;
          tape_writeback <= 1'b1;
          addr <= ptr;
          state <= TAPE_WR;
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
